// File: rtl/ram_load_arbiter_if.sv
// ----------------------------------------------------------------------------
// ram_load_arbiter_if
//   Bundles the three buses that meet at the RAM load arbiter:
//     loader word stream : wd_valid, wd_ready, wd_data[15:8 first], wd_last
//     DMA byte requester : dma_req, dma_gnt, dma_addr, dma_data
//     RAM write port     : ram_we, ram_addr, ram_data
//   slave  modport : seen from the arbiter (owns wd_ready, dma_gnt, ram_*)
//   master modport : seen from the environment (drives loader and DMA)
// ----------------------------------------------------------------------------
interface ram_load_arbiter_if #(
  parameter int ADDR_W = 16
) ();
  logic              wd_valid;
  logic              wd_ready;
  logic [15:0]       wd_data;
  logic              wd_last;

  logic              dma_req;
  logic              dma_gnt;
  logic [ADDR_W-1:0] dma_addr;
  logic [7:0]        dma_data;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_data;

  modport slave (
    input  wd_valid, wd_data, wd_last, dma_req, dma_addr, dma_data,
    output wd_ready, dma_gnt, ram_we, ram_addr, ram_data
  );

  modport master (
    output wd_valid, wd_data, wd_last, dma_req, dma_addr, dma_data,
    input  wd_ready, dma_gnt, ram_we, ram_addr, ram_data
  );
endinterface

// File: rtl/ram_load_arbiter.sv
// ----------------------------------------------------------------------------
// ram_load_arbiter
//   Owns the byte-wide RAM write port. A load session (opened by start)
//   accepts 16-bit loader words, writes the high byte then the low byte to
//   consecutive addresses starting at BASE_ADDR, and shares the port with a
//   single DMA byte requester using round-robin arbitration per word.
//
//   Ports:
//     clk      : rising-edge clock
//     RST      : asynchronous active-low reset
//     bus      : loader / DMA / RAM buses (slave modport)
//     start    : 1-cycle pulse opening a session (ignored while busy)
//     busy     : session open (cycle after start through FIN)
//     done     : 1-cycle pulse in the cycle after the final loader byte
//     overflow : sticky, a loader byte hit the all-ones address
// ----------------------------------------------------------------------------
module ram_load_arbiter #(
  parameter int              ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 16'h000F,
  parameter int              LOAD_WORDS = 1024
) (
  input  logic                  clk,
  input  logic                  RST,
  ram_load_arbiter_if.slave     bus,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int CNT_W = $clog2(LOAD_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_HI,
    S_LO,
    S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_cnt_q;
  logic [CNT_W-1:0]  word_cnt_q;
  logic [7:0]        lo_buf_q;
  logic              last_q;
  logic              prio_loader_q;   // 1: loader wins the next contested slot
  logic              overflow_q;

  logic              end_pending;
  logic              take_word;
  logic              take_dma;
  logic              wd_ready_c;
  logic              dma_gnt_c;

  // Session must close once the last word, the word budget or the top of
  // the address space has been reached; no further words may be taken.
  assign end_pending = last_q || (word_cnt_q == CNT_W'(LOAD_WORDS)) || overflow_q;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // --------------------------------------------------------------------------
  // Next state, handshakes and arbitration
  // --------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    wd_ready_c = 1'b0;
    dma_gnt_c  = 1'b0;
    take_word  = 1'b0;
    take_dma   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        dma_gnt_c = bus.dma_req;
        if (start) state_d = S_WAIT;
      end

      // Word boundary: the only place loader and DMA compete.
      S_WAIT, S_LO: begin
        if (end_pending) begin
          dma_gnt_c = bus.dma_req;
          state_d   = S_FIN;
        end else begin
          // Loader is refused only when DMA is requesting and owns priority.
          wd_ready_c = !(bus.dma_req && !prio_loader_q);
          take_word  = bus.wd_valid && wd_ready_c;
          dma_gnt_c  = bus.dma_req && !take_word;
          state_d    = take_word ? S_HI : S_WAIT;
        end
      end

      // Low byte slot belongs to the word in flight. If the high byte already
      // landed on the all-ones address, the low byte would wrap, so drop it.
      S_HI: state_d = overflow_q ? S_FIN : S_LO;

      S_FIN: begin
        dma_gnt_c = bus.dma_req;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    take_dma = dma_gnt_c;

    // Reset forces every output low, including the combinational handshakes.
    if (!RST) begin
      wd_ready_c = 1'b0;
      dma_gnt_c  = 1'b0;
      take_word  = 1'b0;
      take_dma   = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath: session counters, word buffer, RAM port register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      addr_cnt_q    <= BASE_ADDR;
      word_cnt_q    <= '0;
      lo_buf_q      <= '0;
      last_q        <= 1'b0;
      prio_loader_q <= 1'b1;
      overflow_q    <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_data  <= '0;
    end else begin
      bus.ram_we <= 1'b0;   // address/data hold when nothing is written

      if (state_q == S_IDLE && start) begin
        addr_cnt_q <= BASE_ADDR;
        word_cnt_q <= '0;
        last_q     <= 1'b0;
        overflow_q <= 1'b0;
      end

      if (take_word) begin
        bus.ram_we    <= 1'b1;
        bus.ram_addr  <= addr_cnt_q;
        bus.ram_data  <= bus.wd_data[15:8];
        lo_buf_q      <= bus.wd_data[7:0];
        last_q        <= bus.wd_last;
        word_cnt_q    <= word_cnt_q + 1'b1;
        prio_loader_q <= 1'b0;
        if (addr_cnt_q == '1) overflow_q <= 1'b1;
        else                  addr_cnt_q <= addr_cnt_q + 1'b1;
      end else if (state_q == S_HI && !overflow_q) begin
        bus.ram_we   <= 1'b1;
        bus.ram_addr <= addr_cnt_q;
        bus.ram_data <= lo_buf_q;
        if (addr_cnt_q == '1) overflow_q <= 1'b1;
        else                  addr_cnt_q <= addr_cnt_q + 1'b1;
      end else if (take_dma) begin
        bus.ram_we   <= 1'b1;
        bus.ram_addr <= bus.dma_addr;
        bus.ram_data <= bus.dma_data;
        // Only grants at a word boundary move the round-robin pointer.
        if (state_q == S_WAIT || state_q == S_LO) prio_loader_q <= 1'b1;
      end
    end
  end

  assign bus.wd_ready = wd_ready_c;
  assign bus.dma_gnt  = dma_gnt_c;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_FIN);
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_ram_load_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ram_load_arbiter
//   Directed bench for ram_load_arbiter. u_dut uses the default BASE_ADDR;
//   u_ovf starts at 16'hFFFE to reach the top of the address space.
//   Inputs change 1 time unit after a rising edge; outputs are sampled then.
// ----------------------------------------------------------------------------
module tb_ram_load_arbiter;

  logic clk;
  logic RST;
  logic start_a;
  logic start_b;
  logic busy_a, done_a, ovf_a;
  logic busy_b, done_b, ovf_b;

  int tests;
  int fails;

  ram_load_arbiter_if #(.ADDR_W(16)) bus_a ();
  ram_load_arbiter_if #(.ADDR_W(16)) bus_b ();

  ram_load_arbiter #(.ADDR_W(16), .BASE_ADDR(16'h000F), .LOAD_WORDS(1024)) u_dut (
    .clk      (clk),
    .RST      (RST),
    .bus      (bus_a),
    .start    (start_a),
    .busy     (busy_a),
    .done     (done_a),
    .overflow (ovf_a)
  );

  ram_load_arbiter #(.ADDR_W(16), .BASE_ADDR(16'hFFFE), .LOAD_WORDS(1024)) u_ovf (
    .clk      (clk),
    .RST      (RST),
    .bus      (bus_b),
    .start    (start_b),
    .busy     (busy_b),
    .done     (done_b),
    .overflow (ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: advance past the rising edge so registered outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ram_a(input string tag, input logic we,
                             input logic [15:0] addr, input logic [7:0] data);
    check({tag, ".we"},   {31'd0, bus_a.ram_we}, {31'd0, we});
    check({tag, ".addr"}, {16'd0, bus_a.ram_addr}, {16'd0, addr});
    check({tag, ".data"}, {24'd0, bus_a.ram_data}, {24'd0, data});
  endtask

  task automatic check_ram_b(input string tag, input logic we,
                             input logic [15:0] addr, input logic [7:0] data);
    check({tag, ".we"},   {31'd0, bus_b.ram_we}, {31'd0, we});
    check({tag, ".addr"}, {16'd0, bus_b.ram_addr}, {16'd0, addr});
    check({tag, ".data"}, {24'd0, bus_b.ram_data}, {24'd0, data});
  endtask

  initial begin
    tests = 0;
    fails = 0;
    RST   = 1'b0;
    start_a = 1'b0;  start_b = 1'b0;
    bus_a.wd_valid = 1'b0; bus_a.wd_data = '0; bus_a.wd_last = 1'b0;
    bus_a.dma_req  = 1'b0; bus_a.dma_addr = '0; bus_a.dma_data = '0;
    bus_b.wd_valid = 1'b0; bus_b.wd_data = '0; bus_b.wd_last = 1'b0;
    bus_b.dma_req  = 1'b0; bus_b.dma_addr = '0; bus_b.dma_data = '0;

    // ---- 1: reset held, random inputs, every output low ----
    for (int i = 0; i < 4; i++) begin
      tick();
      start_a        = 1'($urandom);
      bus_a.wd_valid = 1'($urandom);
      bus_a.wd_data  = 16'($urandom);
      bus_a.wd_last  = 1'($urandom);
      bus_a.dma_req  = 1'b1;
      bus_a.dma_addr = 16'($urandom);
      bus_a.dma_data = 8'($urandom);
      #1;
      check("rst.wd_ready", {31'd0, bus_a.wd_ready}, 32'd0);
      check("rst.dma_gnt",  {31'd0, bus_a.dma_gnt},  32'd0);
      check_ram_a("rst.ram", 1'b0, 16'h0000, 8'h00);
      check("rst.flags", {29'd0, busy_a, done_a, ovf_a}, 32'd0);
      check("rst.b_flags", {29'd0, busy_b, done_b, ovf_b}, 32'd0);
    end
    start_a = 1'b0;
    bus_a.wd_valid = 1'b0; bus_a.wd_last = 1'b0; bus_a.dma_req = 1'b0;
    RST = 1'b1;

    // ---- 2: two back-to-back words ----
    tick();
    start_a = 1'b1;
    tick();                                   // WAIT
    start_a = 1'b0;
    check("t2.busy", {31'd0, busy_a}, 32'd1);
    bus_a.wd_valid = 1'b1; bus_a.wd_data = 16'hA55A; bus_a.wd_last = 1'b0;
    #1 check("t2.ready_w0", {31'd0, bus_a.wd_ready}, 32'd1);
    tick();                                   // HI of word 0
    check_ram_a("t2.b0", 1'b1, 16'h000F, 8'hA5);
    bus_a.wd_data = 16'h1234; bus_a.wd_last = 1'b1;
    #1 check("t2.ready_hi", {31'd0, bus_a.wd_ready}, 32'd0);
    tick();                                   // LO of word 0, accept word 1
    check_ram_a("t2.b1", 1'b1, 16'h0010, 8'h5A);
    check("t2.ready_w1", {31'd0, bus_a.wd_ready}, 32'd1);
    tick();
    bus_a.wd_valid = 1'b0; bus_a.wd_last = 1'b0;
    check_ram_a("t2.b2", 1'b1, 16'h0011, 8'h12);
    tick();
    check_ram_a("t2.b3", 1'b1, 16'h0012, 8'h34);
    check("t2.done_early", {31'd0, done_a}, 32'd0);
    tick();                                   // FIN
    check("t2.done", {31'd0, done_a}, 32'd1);
    check_ram_a("t2.hold", 1'b0, 16'h0012, 8'h34);
    check("t2.busy_fin", {31'd0, busy_a}, 32'd1);
    tick();
    check("t2.idle", {30'd0, busy_a, done_a}, 32'd0);

    // ---- 6: DMA while idle ----
    bus_a.dma_req = 1'b1; bus_a.dma_addr = 16'h0040; bus_a.dma_data = 8'h3C;
    #1 check("t6.gnt", {31'd0, bus_a.dma_gnt}, 32'd1);
    tick();
    bus_a.dma_req = 1'b0;
    check_ram_a("t6.wr", 1'b1, 16'h0040, 8'h3C);
    tick();
    check("t6.we_off", {31'd0, bus_a.ram_we}, 32'd0);

    // ---- 3: three words with DMA contending ----
    #2 RST = 1'b0;                            // fresh round-robin pointer
    #2 RST = 1'b1;
    tick();
    start_a = 1'b1;
    tick();                                   // WAIT
    start_a = 1'b0;
    bus_a.wd_valid = 1'b1; bus_a.wd_data = 16'h1122; bus_a.wd_last = 1'b0;
    bus_a.dma_req  = 1'b1; bus_a.dma_addr = 16'h0100; bus_a.dma_data = 8'h77;
    #1;
    check("t3.ready_w0", {31'd0, bus_a.wd_ready}, 32'd1);
    check("t3.gnt_w0",   {31'd0, bus_a.dma_gnt},  32'd0);
    tick();                                   // HI word 0
    check_ram_a("t3.b0", 1'b1, 16'h000F, 8'h11);
    bus_a.wd_data = 16'h3344;
    #1 check("t3.gnt_hi", {31'd0, bus_a.dma_gnt}, 32'd0);
    tick();                                   // LO word 0, DMA wins
    check_ram_a("t3.b1", 1'b1, 16'h0010, 8'h22);
    check("t3.gnt_lo",   {31'd0, bus_a.dma_gnt},  32'd1);
    check("t3.ready_lo", {31'd0, bus_a.wd_ready}, 32'd0);
    tick();                                   // WAIT, DMA byte on port
    bus_a.dma_req = 1'b0;
    check_ram_a("t3.dma", 1'b1, 16'h0100, 8'h77);
    #1 check("t3.ready_w1", {31'd0, bus_a.wd_ready}, 32'd1);
    tick();
    check_ram_a("t3.b2", 1'b1, 16'h0011, 8'h33);
    bus_a.wd_data = 16'h5566; bus_a.wd_last = 1'b1;
    tick();
    check_ram_a("t3.b3", 1'b1, 16'h0012, 8'h44);
    tick();
    bus_a.wd_valid = 1'b0; bus_a.wd_last = 1'b0;
    check_ram_a("t3.b4", 1'b1, 16'h0013, 8'h55);
    tick();
    check_ram_a("t3.b5", 1'b1, 16'h0014, 8'h66);
    tick();
    check("t3.done", {31'd0, done_a}, 32'd1);
    tick();

    // ---- 4: top of address space on u_ovf ----
    start_b = 1'b1;
    tick();                                   // WAIT
    start_b = 1'b0;
    bus_b.wd_valid = 1'b1; bus_b.wd_data = 16'hABCD; bus_b.wd_last = 1'b0;
    #1 check("t4.ready_w0", {31'd0, bus_b.wd_ready}, 32'd1);
    tick();                                   // HI
    check_ram_b("t4.b0", 1'b1, 16'hFFFE, 8'hAB);
    check("t4.ovf_hi", {31'd0, ovf_b}, 32'd0);
    bus_b.wd_data = 16'hEF01;
    tick();                                   // LO at FFFF
    check_ram_b("t4.b1", 1'b1, 16'hFFFF, 8'hCD);
    check("t4.ovf", {31'd0, ovf_b}, 32'd1);
    check("t4.ready_lo", {31'd0, bus_b.wd_ready}, 32'd0);
    tick();                                   // FIN
    check("t4.done", {31'd0, done_b}, 32'd1);
    check("t4.no_w1", {31'd0, bus_b.ram_we}, 32'd0);
    check("t4.ready_fin", {31'd0, bus_b.wd_ready}, 32'd0);
    tick();
    bus_b.wd_valid = 1'b0;
    check("t4.idle", {30'd0, busy_b, ovf_b}, 32'd1);
    check("t4.no_wrap", {31'd0, bus_b.ram_we}, 32'd0);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("t4.ovf_clr", {30'd0, busy_b, ovf_b}, 32'd2);

    // ---- 5: reset in the middle of a word ----
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    bus_a.wd_valid = 1'b1; bus_a.wd_data = 16'hBEEF; bus_a.wd_last = 1'b0;
    tick();                                   // HI on port
    check_ram_a("t5.hi", 1'b1, 16'h000F, 8'hBE);
    bus_a.wd_valid = 1'b0;
    #2 RST = 1'b0;
    #1 check_ram_a("t5.rst", 1'b0, 16'h0000, 8'h00);
    tick();
    check("t5.no_lo", {31'd0, bus_a.ram_we}, 32'd0);
    #2 RST = 1'b1;
    tick();
    check("t5.still_idle", {30'd0, bus_a.ram_we, busy_a}, 32'd0);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    bus_a.wd_valid = 1'b1; bus_a.wd_data = 16'h9876; bus_a.wd_last = 1'b1;
    tick();
    bus_a.wd_valid = 1'b0; bus_a.wd_last = 1'b0;
    check_ram_a("t5.base", 1'b1, 16'h000F, 8'h98);
    tick();
    check_ram_a("t5.lo", 1'b1, 16'h0010, 8'h76);
    tick();
    check("t5.done", {31'd0, done_a}, 32'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
